sram_like_bram_slave: RTL and testbench



---
 rtl/sram_like_bram_slave.sv | 108 ++++++++++
 tb/tb_sram_like_bram_slave.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_like_bram_slave.sv
// SRAM-like bus responder around a word-addressed block RAM: in-order completion,
// fixed minimum data latency, optional LFSR-driven stalls on both handshakes.
module sram_like_bram_slave #(
    parameter int unsigned ADDR_WIDTH      = 14,
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter int unsigned DATA_LAT        = 1,
    parameter int unsigned RAND_DELAY      = 0,
    parameter logic [7:0]  LFSR_SEED       = 8'h5A
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        wr,
    input  logic [1:0]  size,
    input  logic [3:0]  wstrb,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        addr_ok,
    output logic        data_ok,
    output logic [31:0] rdata
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
    localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned LAT_W = (DATA_LAT > 1) ? $clog2(DATA_LAT) : 1;

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(MAX_OUTSTANDING);
    localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(DATA_LAT - 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(MAX_OUTSTANDING - 1);
    localparam logic             STALL_EN = (RAND_DELAY != 0);

    logic [31:0]      mem [DEPTH];
    logic [31:0]      mem_word;
    logic [ADDR_WIDTH-1:0] idx;

    logic             q_wr   [MAX_OUTSTANDING];
    logic [31:0]      q_data [MAX_OUTSTANDING];
    logic [LAT_W-1:0] q_cnt  [MAX_OUTSTANDING];

    logic [PTR_W-1:0] head, tail;
    logic [CNT_W-1:0] count;
    logic [7:0]       lfsr;
    logic             addr_stall, data_stall, full, accept, head_valid;
    logic             unused_bits;

    function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        idx         = addr[ADDR_WIDTH+1:2];
        mem_word    = mem[idx];
        addr_stall  = STALL_EN & lfsr[0];
        data_stall  = STALL_EN & lfsr[1];
        full        = (count == FULL_CNT);
        head_valid  = (count != '0);
        addr_ok     = req & ~full & ~addr_stall;
        accept      = req & addr_ok;
        data_ok     = ~reset & head_valid & (q_cnt[head] == '0) & ~data_stall;
        rdata       = (data_ok & ~q_wr[head]) ? q_data[head] : '0;
        unused_bits = ^{size, addr[31:ADDR_WIDTH+2], addr[1:0]};
    end

    // Memory is deliberately not reset so accepted writes survive a mid-run reset.
    always_ff @(posedge clk) begin
        if (accept && wr) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (wstrb[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        end
    end

    // Read data is captured at accept, so it reflects memory before a same-edge write.
    always_ff @(posedge clk) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int unsigned i = 0; i < MAX_OUTSTANDING; i++) q_cnt[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < MAX_OUTSTANDING; i++) begin
                if (q_cnt[i] != '0) q_cnt[i] <= q_cnt[i] - 1'b1;
            end
            if (accept) begin
                q_wr[tail]   <= wr;
                q_data[tail] <= mem_word;
                q_cnt[tail]  <= LAT_INIT;
                tail         <= bump(tail);
            end
            if (data_ok) head <= bump(head);
            case ({accept, data_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_like_bram_slave.sv
// Directed and random bench for sram_like_bram_slave across three configurations,
// with a scoreboard of expected completions and retire cycles.
module tb_sram_like_bram_slave;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_v   [3];
    logic        wr_v    [3];
    logic [1:0]  size_v  [3];
    logic [3:0]  wstrb_v [3];
    logic [31:0] addr_v  [3];
    logic [31:0] wdata_v [3];
    logic        addr_ok_v [3];
    logic        data_ok_v [3];
    logic [31:0] rdata_v   [3];

    always #5 clk = ~clk;

    sram_like_bram_slave #(.ADDR_WIDTH(14), .MAX_OUTSTANDING(2), .DATA_LAT(1), .RAND_DELAY(0), .LFSR_SEED(8'h5A)) u0 (
        .clk(clk), .reset(reset), .req(req_v[0]), .wr(wr_v[0]), .size(size_v[0]), .wstrb(wstrb_v[0]),
        .addr(addr_v[0]), .wdata(wdata_v[0]), .addr_ok(addr_ok_v[0]), .data_ok(data_ok_v[0]), .rdata(rdata_v[0]));
    sram_like_bram_slave #(.ADDR_WIDTH(14), .MAX_OUTSTANDING(2), .DATA_LAT(3), .RAND_DELAY(0), .LFSR_SEED(8'h5A)) u1 (
        .clk(clk), .reset(reset), .req(req_v[1]), .wr(wr_v[1]), .size(size_v[1]), .wstrb(wstrb_v[1]),
        .addr(addr_v[1]), .wdata(wdata_v[1]), .addr_ok(addr_ok_v[1]), .data_ok(data_ok_v[1]), .rdata(rdata_v[1]));
    sram_like_bram_slave #(.ADDR_WIDTH(14), .MAX_OUTSTANDING(2), .DATA_LAT(2), .RAND_DELAY(1), .LFSR_SEED(8'h5A)) u2 (
        .clk(clk), .reset(reset), .req(req_v[2]), .wr(wr_v[2]), .size(size_v[2]), .wstrb(wstrb_v[2]),
        .addr(addr_v[2]), .wdata(wdata_v[2]), .addr_ok(addr_ok_v[2]), .data_ok(data_ok_v[2]), .rdata(rdata_v[2]));

    typedef struct {
        logic        wr;
        logic [31:0] data;
        int          ret;
    } exp_t;

    int          lat_tab [3] = '{1, 3, 2};
    bit          rnd_tab [3] = '{1'b0, 1'b0, 1'b1};
    exp_t        sb [$];
    int          rets [$];
    logic [31:0] model [int];
    exp_t        mon_e;
    int          checks = 0;
    int          errors = 0;
    int          cur = 0;
    int          cyc = 0;
    int          last_ret = 0;
    int          pre_size = 0;
    int          acc_cnt = 0;
    int          dok_cnt [3] = '{0, 0, 0};

    always @(posedge clk) cyc <= cyc + 1;

    // Completion monitor: every data_ok must match the oldest expected transaction.
    always @(negedge clk) begin
        pre_size = sb.size();
        for (int s = 0; s < 3; s++) begin
            if (data_ok_v[s]) begin
                dok_cnt[s]++;
                checks++;
                assert ((s == cur && sb.size() != 0) === 1'b1) else begin
                    errors++;
                    $error("FAIL spurious_data_ok dut=%0d cyc=%0d observed=1 expected=0", s, cyc);
                end
                if (s == cur && sb.size() != 0) begin
                    mon_e = sb.pop_front();
                    checks++;
                    assert (rdata_v[s] === (mon_e.wr ? 32'h0 : mon_e.data)) else begin
                        errors++;
                        $error("FAIL rdata dut=%0d cyc=%0d observed=%h expected=%h", s, cyc, rdata_v[s],
                               mon_e.wr ? 32'h0 : mon_e.data);
                    end
                    if (!rnd_tab[s]) begin
                        checks++;
                        assert (cyc === mon_e.ret) else begin
                            errors++;
                            $error("FAIL retire_cycle dut=%0d observed=%0d expected=%0d", s, cyc, mon_e.ret);
                        end
                    end
                end
            end else if (s == cur) begin
                checks++;
                assert (rdata_v[s] === 32'h0) else begin
                    errors++;
                    $error("FAIL rdata_idle dut=%0d cyc=%0d observed=%h expected=0", s, cyc, rdata_v[s]);
                end
            end
        end
    end

    // Starts and ends just after a rising edge; holds req until accepted.
    task automatic issue(input int s, input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] st);
        bit          done = 1'b0;
        int          key;
        int          live;
        logic [31:0] old;
        logic [31:0] nw;
        exp_t        e;
        req_v[s] = 1'b1; wr_v[s] = w; addr_v[s] = a; wdata_v[s] = d; wstrb_v[s] = st; size_v[s] = 2'd2;
        for (int n = 0; n < 100 && !done; n++) begin
            @(negedge clk); #1;
            if (!rnd_tab[s]) begin
                live = 0;
                foreach (rets[i]) if (rets[i] >= cyc) live++;
                checks++;
                assert (addr_ok_v[s] === (live < 2)) else begin
                    errors++;
                    $error("FAIL addr_ok dut=%0d cyc=%0d observed=%b expected=%b", s, cyc, addr_ok_v[s], live < 2);
                end
            end
            if (addr_ok_v[s]) begin
                checks++;
                assert ((pre_size < 2) === 1'b1) else begin
                    errors++;
                    $error("FAIL outstanding dut=%0d cyc=%0d observed=%0d expected<2", s, cyc, pre_size);
                end
                key = s * 65536 + int'(a[15:2]);
                old = model.exists(key) ? model[key] : 32'h0;
                e.wr = w;
                e.data = old;
                e.ret = (cyc + lat_tab[s] > last_ret + 1) ? cyc + lat_tab[s] : last_ret + 1;
                last_ret = e.ret;
                rets.push_back(e.ret);
                sb.push_back(e);
                acc_cnt++;
                if (w) begin
                    nw = old;
                    for (int b = 0; b < 4; b++) if (st[b]) nw[8*b +: 8] = d[8*b +: 8];
                    model[key] = nw;
                end
                done = 1'b1;
            end
            @(posedge clk); #1;
        end
        req_v[s] = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $error("FAIL accept_timeout dut=%0d observed=no_addr_ok expected=accept", s);
        end
    endtask

    task automatic wait_idle();
        for (int n = 0; n < 200 && sb.size() != 0; n++) @(negedge clk);
        @(posedge clk); #1;
        checks++;
        assert (sb.size() === 0) else begin
            errors++;
            $error("FAIL drain_timeout dut=%0d observed=%0d expected=0", cur, sb.size());
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        int a0;
        int pick;
        reset = 1'b1;
        for (int s = 0; s < 3; s++) begin
            req_v[s] = 1'b0; wr_v[s] = 1'b0; size_v[s] = 2'd0; wstrb_v[s] = 4'h0; addr_v[s] = '0; wdata_v[s] = '0;
        end
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            checks += 3;
            assert (data_ok_v[s] === 1'b0) else begin errors++; $error("FAIL reset_data_ok dut=%0d observed=%b expected=0", s, data_ok_v[s]); end
            assert (rdata_v[s] === 32'h0) else begin errors++; $error("FAIL reset_rdata dut=%0d observed=%h expected=0", s, rdata_v[s]); end
            assert (addr_ok_v[s] === 1'b0) else begin errors++; $error("FAIL reset_addr_ok dut=%0d observed=%b expected=0", s, addr_ok_v[s]); end
        end
        @(posedge clk); #1;

        // DATA_LAT=1: write then read-after-write, byte strobes, zero-strobe write.
        cur = 0; rets.delete();
        issue(0, 1'b1, 32'h1C00_0000, 32'hDEAD_BEEF, 4'hF);
        issue(0, 1'b0, 32'h1C00_0000, 32'h0, 4'h0);
        issue(0, 1'b1, 32'h0000_0100, 32'h1122_3344, 4'hF);
        issue(0, 1'b1, 32'h0000_0100, 32'hAABB_CCDD, 4'b0101);
        issue(0, 1'b0, 32'h0000_0100, 32'h0, 4'h0);
        issue(0, 1'b1, 32'h0000_0102, 32'h5555_5555, 4'h0);
        issue(0, 1'b0, 32'h0000_0103, 32'h0, 4'h0);
        wait_idle();
        checks++;
        assert (model[256 / 4] === 32'h11BB_33DD) else begin
            errors++; $error("FAIL strobe_model observed=%h expected=11bb33dd", model[256 / 4]);
        end

        // DATA_LAT=3, MAX_OUTSTANDING=2: full blocking, pop+push at full, burst of 8.
        cur = 1; rets.delete();
        for (int k = 0; k < 3; k++) issue(1, 1'b1, 32'h0000_0200 + 32'(4 * k), 32'hA000_0000 + 32'(k), 4'hF);
        for (int k = 0; k < 3; k++) issue(1, 1'b0, 32'h0000_0200 + 32'(4 * k), 32'h0, 4'h0);
        wait_idle();
        d0 = dok_cnt[1];
        for (int k = 0; k < 8; k++) issue(1, 1'b0, 32'h0000_0200 + 32'(4 * (k % 3)), 32'h0, 4'h0);
        wait_idle();
        checks++;
        assert ((dok_cnt[1] - d0) === 8) else begin
            errors++; $error("FAIL burst_count observed=%0d expected=8", dok_cnt[1] - d0);
        end

        // Random stalls: preload 8 words then 200 random accesses.
        cur = 2; rets.delete();
        d0 = dok_cnt[2];
        a0 = acc_cnt;
        for (int k = 0; k < 8; k++) issue(2, 1'b1, 32'h0000_0400 + 32'(4 * k), $urandom, 4'hF);
        for (int k = 0; k < 200; k++) begin
            pick = $urandom_range(0, 7);
            issue(2, 1'($urandom_range(0, 1)), 32'h0000_0400 + 32'(4 * pick), $urandom, 4'($urandom_range(0, 15)));
            if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
        end
        wait_idle();
        checks++;
        assert ((dok_cnt[2] - d0) === (acc_cnt - a0)) else begin
            errors++; $error("FAIL random_count observed=%0d expected=%0d", dok_cnt[2] - d0, acc_cnt - a0);
        end

        // Reset with two reads outstanding: both dropped, memory retained.
        cur = 1; rets.delete();
        issue(1, 1'b0, 32'h0000_0200, 32'h0, 4'h0);
        issue(1, 1'b0, 32'h0000_0204, 32'h0, 4'h0);
        reset = 1'b1;
        sb.delete(); rets.delete(); last_ret = 0;
        d0 = dok_cnt[1];
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        checks++;
        assert ((dok_cnt[1] - d0) === 0) else begin
            errors++; $error("FAIL reset_drop observed=%0d expected=0", dok_cnt[1] - d0);
        end
        issue(1, 1'b0, 32'h0000_0208, 32'h0, 4'h0);
        wait_idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
